lifo_gen: RTL and testbench

Parametrised last-in/first-out data stack for the stack-machine cores: DEPTH elements of WIDTH bits held as a shift-register stack with the top two elements exposed. It extends the fixed-depth stack with asynchronous reset, an element count, full/empty status, sticky overflow/underflow flags, and a wider stack-effect set (DUP, NIP, TUCK, -ROT, CLEAR). It sits beside the ALU and is driven by the instruction decoder one stack effect per cycle.

---
 rtl/lifo_gen_pkg.sv | 41 ++++
 rtl/lifo_gen_cnt.sv | 77 +++++++
 rtl/lifo_gen_ses.vh | 20 ++
 rtl/lifo_gen.sv | 153 +++++++++++++++
 tb/tb_lifo_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/lifo_gen_pkg.sv
// ============================================================================
// lifo_gen_pkg : stack-effect codes and decode types for lifo_gen.
// Rev 1.0
// ============================================================================
`default_nettype none

package lifo_gen_pkg;

    // Values mirror lifo_gen_ses.vh so decoder and stack agree.
    typedef enum logic [3:0] {
        SE_NONE  = 4'd0,
        SE_DROP  = 4'd1,
        SE_PUSH  = 4'd2,
        SE_RPLC  = 4'd3,
        SE_SWAP  = 4'd4,
        SE_OVER  = 4'd5,
        SE_ZDUP  = 4'd6,
        SE_ROT3  = 4'd7,
        SE_DUP   = 4'd8,
        SE_NIP   = 4'd9,
        SE_TUCK  = 4'd10,
        SE_MROT  = 4'd11,
        SE_CLEAR = 4'd12
    } se_e;

    typedef enum logic [1:0] {
        DLT_ZERO = 2'd0,
        DLT_INC  = 2'd1,
        DLT_DEC  = 2'd2
    } delta_e;

    typedef enum logic [1:0] {
        SH_HOLD = 2'd0,
        SH_DOWN = 2'd1,
        SH_UP   = 2'd2,
        SH_ZERO = 2'd3
    } shift_e;

endpackage

`default_nettype wire

// File: rtl/lifo_gen_cnt.sv
// ============================================================================
// lifo_gen_cnt : element count, full/empty status and sticky ovf/unf flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module lifo_gen_cnt
    import lifo_gen_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_req,
    input  delta_e        i_dlt,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_ovf,
    output logic          o_unf
);

    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_q, full_q, ovf_q, unf_q;
    logic          ovf_d, unf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q | (cnt_q < CW'(i_req));
        case (i_dlt)
            DLT_INC: begin
                if (cnt_q == C_FULL) ovf_d = 1'b1;
                else                 cnt_d = cnt_q + CW'(1);
            end
            DLT_DEC: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            default: ;
        endcase
        // Clear dominates any flag raised by the same operation.
        if (i_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == C_FULL);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_empty = empty_q;
    assign o_full  = full_q;
    assign o_ovf   = ovf_q;
    assign o_unf   = unf_q;

endmodule

`default_nettype wire

// File: rtl/lifo_gen_ses.vh
// ============================================================================
// lifo_gen_ses.vh : 4-bit stack-effect encodings shared with the decoder.
// Rev 1.0
// ============================================================================
`ifndef LIFO_GEN_SES_VH
`define LIFO_GEN_SES_VH
`define SE_NONE  4'd0
`define SE_DROP  4'd1
`define SE_PUSH  4'd2
`define SE_RPLC  4'd3
`define SE_SWAP  4'd4
`define SE_OVER  4'd5
`define SE_ZDUP  4'd6
`define SE_ROT3  4'd7
`define SE_DUP   4'd8
`define SE_NIP   4'd9
`define SE_TUCK  4'd10
`define SE_MROT  4'd11
`define SE_CLEAR 4'd12
`endif

// File: rtl/lifo_gen.sv
// ============================================================================
// lifo_gen : parametrised shift-register LIFO with top two elements exposed.
// Rev 1.0
// ============================================================================
`default_nettype none

module lifo_gen
    import lifo_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_se,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1,
    output logic [CW-1:0]    o_cnt,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf,
    output logic             o_unf
);

    logic [WIDTH-1:0] w_stk [DEPTH];
    logic [WIDTH-1:0] w_up  [DEPTH];
    logic [WIDTH-1:0] w_t0, w_t1, w_t2;
    shift_e           w_sh;
    logic [1:0]       w_req;
    delta_e           w_dlt;
    logic             w_clr;

    // Top three slots get explicit values; deeper slots follow w_sh.
    always_comb begin
        w_t0  = w_stk[0];
        w_t1  = w_stk[1];
        w_t2  = w_stk[2];
        w_sh  = SH_HOLD;
        w_req = 2'd0;
        w_dlt = DLT_ZERO;
        w_clr = 1'b0;
        case (i_se)
            SE_DROP: begin
                w_t0 = w_stk[1]; w_t1 = w_stk[2]; w_t2 = w_up[2];
                w_sh = SH_UP; w_req = 2'd1; w_dlt = DLT_DEC;
            end
            SE_PUSH: begin
                w_t0 = i_data; w_t1 = w_stk[0]; w_t2 = w_stk[1];
                w_sh = SH_DOWN; w_dlt = DLT_INC;
            end
            SE_RPLC: begin
                w_t0 = i_data; w_req = 2'd1;
            end
            SE_SWAP: begin
                w_t0 = w_stk[1]; w_t1 = w_stk[0]; w_req = 2'd2;
            end
            SE_OVER: begin
                w_t0 = w_stk[1]; w_t1 = w_stk[0]; w_t2 = w_stk[1];
                w_sh = SH_DOWN; w_req = 2'd2; w_dlt = DLT_INC;
            end
            SE_ZDUP: begin
                w_req = 2'd1;
                // Decision on the pre-edge top; a zero top leaves the stack alone.
                if (w_stk[0] != '0) begin
                    w_t1 = w_stk[0]; w_t2 = w_stk[1];
                    w_sh = SH_DOWN; w_dlt = DLT_INC;
                end
            end
            SE_ROT3: begin
                w_t0 = w_stk[2]; w_t1 = w_stk[0]; w_t2 = w_stk[1]; w_req = 2'd3;
            end
            SE_DUP: begin
                w_t1 = w_stk[0]; w_t2 = w_stk[1];
                w_sh = SH_DOWN; w_req = 2'd1; w_dlt = DLT_INC;
            end
            SE_NIP: begin
                w_t1 = w_stk[2]; w_t2 = w_up[2];
                w_sh = SH_UP; w_req = 2'd2; w_dlt = DLT_DEC;
            end
            SE_TUCK: begin
                w_t2 = w_stk[0];
                w_sh = SH_DOWN; w_req = 2'd2; w_dlt = DLT_INC;
            end
            SE_MROT: begin
                w_t0 = w_stk[1]; w_t1 = w_stk[2]; w_t2 = w_stk[0]; w_req = 2'd3;
            end
            SE_CLEAR: begin
                w_t0 = '0; w_t1 = '0; w_t2 = '0;
                w_sh = SH_ZERO; w_clr = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stk
        logic [WIDTH-1:0] elem_q, elem_d;

        // Shifting up fills the bottom slot with zero.
        if (k + 1 < DEPTH) begin : g_up
            assign w_up[k] = w_stk[k+1];
        end else begin : g_up_last
            assign w_up[k] = '0;
        end

        if (k == 0) begin : g_s0
            assign elem_d = w_t0;
        end else if (k == 1) begin : g_s1
            assign elem_d = w_t1;
        end else if (k == 2) begin : g_s2
            assign elem_d = w_t2;
        end else begin : g_deep
            always_comb begin
                case (w_sh)
                    SH_DOWN: elem_d = w_stk[k-1];
                    SH_UP:   elem_d = w_up[k];
                    SH_ZERO: elem_d = '0;
                    default: elem_d = elem_q;
                endcase
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) elem_q <= '0;
            else       elem_q <= elem_d;
        end

        assign w_stk[k] = elem_q;
    end

    lifo_gen_cnt #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (w_req),
        .i_dlt   (w_dlt),
        .i_clr   (w_clr),
        .o_cnt   (o_cnt),
        .o_empty (o_empty),
        .o_full  (o_full),
        .o_ovf   (o_ovf),
        .o_unf   (o_unf)
    );

    assign o_s0 = w_stk[0];
    assign o_s1 = w_stk[1];

endmodule

`default_nettype wire

// File: tb/tb_lifo_gen.sv
// ============================================================================
// tb_lifo_gen : directed vector bench for lifo_gen (WIDTH=8, DEPTH=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lifo_gen;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    localparam logic [3:0] NONE = 4'd0,  DROP = 4'd1,  PUSH = 4'd2,  RPLC = 4'd3;
    localparam logic [3:0] SWAP = 4'd4,  OVER = 4'd5,  ZDUP = 4'd6,  ROT3 = 4'd7;
    localparam logic [3:0] DUP  = 4'd8,  NIP  = 4'd9,  TUCK = 4'd10, MROT = 4'd11;
    localparam logic [3:0] CLR  = 4'd12, RS13 = 4'd13, RS15 = 4'd15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    se  = 4'd0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  s0, s1;
    logic [CW-1:0] cnt;
    logic          empty, full, ovf, unf;

    lifo_gen #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_se    (se),
        .i_data  (din),
        .o_s0    (s0),
        .o_s1    (s1),
        .o_cnt   (cnt),
        .o_empty (empty),
        .o_full  (full),
        .o_ovf   (ovf),
        .o_unf   (unf)
    );

    always #5 clk = ~clk;

    // fl = {empty, full, ovf, unf}
    typedef struct {
        logic [3:0] se;
        logic [7:0] d;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [2:0] cnt;
        logic [3:0] fl;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [3:0] s, input logic [7:0] d, input logic [7:0] e0,
                       input logic [7:0] e1, input logic [2:0] c, input logic [3:0] f);
        vec_t v;
        v.se = s; v.d = d; v.s0 = e0; v.s1 = e1; v.cnt = c; v.fl = f;
        vt.push_back(v);
    endtask

    function automatic logic [22:0] state();
        return {s0, s1, cnt, empty, full, ovf, unf};
    endfunction

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = state();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got s0=%h s1=%h cnt=%0d efou=%b, want s0=%h s1=%h cnt=%0d efou=%b",
                     name, act[22:15], act[14:7], act[6:4], act[3:0],
                     exp[22:15], exp[14:7], exp[6:4], exp[3:0]);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [7:0] d);
        @(negedge clk);
        se  = s;
        din = d;
        @(posedge clk);
        #1;
        se  = NONE;
    endtask

    initial begin
        // Basic movement and rotations
        add(PUSH, 8'h11, 8'h11, 8'h00, 3'd1, 4'b0000);
        add(PUSH, 8'h22, 8'h22, 8'h11, 3'd2, 4'b0000);
        add(PUSH, 8'h33, 8'h33, 8'h22, 3'd3, 4'b0000);
        add(ROT3, 8'h00, 8'h11, 8'h33, 3'd3, 4'b0000);
        add(MROT, 8'h00, 8'h33, 8'h22, 3'd3, 4'b0000);
        add(SWAP, 8'h00, 8'h22, 8'h33, 3'd3, 4'b0000);
        add(OVER, 8'h00, 8'h33, 8'h22, 3'd4, 4'b0100);
        add(RPLC, 8'h44, 8'h44, 8'h22, 3'd4, 4'b0100);
        add(DUP,  8'h00, 8'h44, 8'h44, 3'd4, 4'b0110);
        add(CLR,  8'h00, 8'h00, 8'h00, 3'd0, 4'b1000);
        // Overflow then drain: value 1 must be lost
        add(PUSH, 8'h01, 8'h01, 8'h00, 3'd1, 4'b0000);
        add(PUSH, 8'h02, 8'h02, 8'h01, 3'd2, 4'b0000);
        add(PUSH, 8'h03, 8'h03, 8'h02, 3'd3, 4'b0000);
        add(PUSH, 8'h04, 8'h04, 8'h03, 3'd4, 4'b0100);
        add(PUSH, 8'h05, 8'h05, 8'h04, 3'd4, 4'b0110);
        add(DROP, 8'h00, 8'h04, 8'h03, 3'd3, 4'b0010);
        add(DROP, 8'h00, 8'h03, 8'h02, 3'd2, 4'b0010);
        add(DROP, 8'h00, 8'h02, 8'h00, 3'd1, 4'b0010);
        add(DROP, 8'h00, 8'h00, 8'h00, 3'd0, 4'b1010);
        // Underflow from empty, sticky across a push
        add(DROP, 8'h00, 8'h00, 8'h00, 3'd0, 4'b1011);
        add(PUSH, 8'hAA, 8'hAA, 8'h00, 3'd1, 4'b0011);
        add(CLR,  8'h00, 8'h00, 8'h00, 3'd0, 4'b1000);
        // ZDUP on zero and non-zero top
        add(PUSH, 8'h00, 8'h00, 8'h00, 3'd1, 4'b0000);
        add(ZDUP, 8'h00, 8'h00, 8'h00, 3'd1, 4'b0000);
        add(PUSH, 8'h07, 8'h07, 8'h00, 3'd2, 4'b0000);
        add(ZDUP, 8'h00, 8'h07, 8'h07, 3'd3, 4'b0000);
        add(CLR,  8'h00, 8'h00, 8'h00, 3'd0, 4'b1000);
        // TUCK / NIP, reserved codes
        add(PUSH, 8'h01, 8'h01, 8'h00, 3'd1, 4'b0000);
        add(PUSH, 8'h02, 8'h02, 8'h01, 3'd2, 4'b0000);
        add(TUCK, 8'h00, 8'h02, 8'h01, 3'd3, 4'b0000);
        add(NIP,  8'h00, 8'h02, 8'h02, 3'd2, 4'b0000);
        add(NIP,  8'h00, 8'h02, 8'h00, 3'd1, 4'b0000);
        add(RS13, 8'hFF, 8'h02, 8'h00, 3'd1, 4'b0000);
        add(RS15, 8'hFF, 8'h02, 8'h00, 3'd1, 4'b0000);
        // Underflowing ops still move data
        add(SWAP, 8'h00, 8'h00, 8'h02, 3'd1, 4'b0001);
        add(NONE, 8'hFF, 8'h00, 8'h02, 3'd1, 4'b0001);
        add(RPLC, 8'h3C, 8'h3C, 8'h02, 3'd1, 4'b0001);
        add(CLR,  8'h00, 8'h00, 8'h00, 3'd0, 4'b1000);
        add(ROT3, 8'h00, 8'h00, 8'h00, 3'd0, 4'b1001);
        add(CLR,  8'h00, 8'h00, 8'h00, 3'd0, 4'b1000);
        add(DUP,  8'h00, 8'h00, 8'h00, 3'd1, 4'b0001);
        add(CLR,  8'h00, 8'h00, 8'h00, 3'd0, 4'b1000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {8'h00, 8'h00, 3'd0, 4'b1000});
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].se, vt[i].d);
            check($sformatf("vec%0d", i), {vt[i].s0, vt[i].s1, vt[i].cnt, vt[i].fl});
        end

        // Asynchronous reset between edges in the middle of a push stream
        step(PUSH, 8'h61);
        step(PUSH, 8'h62);
        check("pre_rst", {8'h62, 8'h61, 3'd2, 4'b0000});
        se  = PUSH;
        din = 8'h63;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", {8'h00, 8'h00, 3'd0, 4'b1000});
        @(posedge clk);
        #1;
        check("rst_hold", {8'h00, 8'h00, 3'd0, 4'b1000});
        @(negedge clk);
        rst = 1'b0;
        se  = NONE;
        step(PUSH, 8'h5A);
        check("post_rst_push", {8'h5A, 8'h00, 3'd1, 4'b0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
